// File: rtl/inverse_actuator_pkg.sv
// ---------------------------------------------------------------------------
// inv_act_pkg
// Shared definitions for the inverse actuator: one-hot FSM state encoding,
// default parameter values and the saturation constants for a given output
// width.
// Optional build macro (consumed by inverse_actuator): INV_ACT_ROUND_EN.
// ---------------------------------------------------------------------------
package inv_act_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_FRAC   = 14;
   localparam int DEF_OUT_W  = 32;

   // One-hot FSM state, 4 bits
   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'b0001;
   localparam state_t ST_PREP   = 4'b0010;
   localparam state_t ST_DIV    = 4'b0100;
   localparam state_t ST_FINISH = 4'b1000;

   // Largest positive value of a signed outW-bit word (outW <= 64)
   function automatic logic signed [63:0] SAT_POS(input int outW);
      return (64'sd1 <<< (outW - 1)) - 64'sd1;
   endfunction

   // Symmetric negative limit, -(2^(outW-1)-1)
   function automatic logic signed [63:0] SAT_NEG(input int outW);
      return -SAT_POS(outW);
   endfunction

endpackage

// File: rtl/inverse_actuator_if.sv
// ---------------------------------------------------------------------------
// inverse_actuator_if
// Request/result bundle of the inverse actuator.
//   iData     : signed Q(FRAC) activation value y
//   iEn       : start request, honoured only while the block is idle
//   oData     : signed Q(FRAC) result x = y/(1-|y|)
//   oComplete : one-cycle pulse, oData/oSat newly valid
//   oBusy     : high while an operation is in flight
//   oSat      : result was saturated, valid with oData
// Handshake: a request is taken on a rising edge where iEn=1 and oBusy=0;
// there is no back-pressure on the result, which is announced by oComplete
// and then held until the next result replaces it.
// Optional build macro (consumed by inverse_actuator): INV_ACT_ROUND_EN.
// ---------------------------------------------------------------------------
interface inverse_actuator_if #(
   parameter int DATA_W = inv_act_pkg::DEF_DATA_W,
   parameter int OUT_W  = inv_act_pkg::DEF_OUT_W
) ();

   logic signed [DATA_W-1:0] iData;
   logic                     iEn;
   logic signed [OUT_W-1:0]  oData;
   logic                     oComplete;
   logic                     oBusy;
   logic                     oSat;

   modport master (
      output iData, iEn,
      input  oData, oComplete, oBusy, oSat
   );

   modport slave (
      input  iData, iEn,
      output oData, oComplete, oBusy, oSat
   );

endinterface

// File: rtl/inverse_actuator_serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
// Unsigned restoring long division, one quotient bit per clock, MSB first.
// The first step is taken on the same edge that loads the operands, so
// ITER steps finish ITER edges after iStart and oComplete pulses in the
// cycle following the last step.
//   iClk, iRst_n : clock, synchronous active-low reset
//   iStart       : load operands and perform the first step
//   iDividend    : DIVIDEND_W-bit unsigned dividend
//   iDivisor     : DIVISOR_W-bit unsigned divisor (non-zero)
//   oQuotient    : quotient, valid with oComplete
//   oRemainder   : final partial remainder, valid with oComplete
//   oComplete    : one-cycle pulse after the last step
// Optional build macro (consumed by inverse_actuator): INV_ACT_ROUND_EN.
// ---------------------------------------------------------------------------
module serial_divider #(
   parameter int DIVIDEND_W = 28,
   parameter int DIVISOR_W  = 15,
   parameter int ITER       = DIVIDEND_W
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic                  iStart,
   input  logic [DIVIDEND_W-1:0] iDividend,
   input  logic [DIVISOR_W-1:0]  iDivisor,
   output logic [DIVIDEND_W-1:0] oQuotient,
   output logic [DIVISOR_W-1:0]  oRemainder,
   output logic                  oComplete
);

   localparam int CNT_W = $clog2(ITER + 1);

   logic [DIVISOR_W-1:0]  remReg;
   logic [DIVISOR_W-1:0]  divReg;
   logic [DIVIDEND_W-1:0] quoReg;
   logic [CNT_W-1:0]      cnt;
   logic                  busy;

   logic [DIVISOR_W-1:0]  srcRem;
   logic [DIVISOR_W-1:0]  srcDiv;
   logic [DIVIDEND_W-1:0] srcQuo;
   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W:0]    diff;
   logic                  take;
   logic [DIVISOR_W-1:0]  nextRem;

   // On iStart the step works on the fresh operands instead of the registers
   always_comb begin
      srcRem  = iStart ? '0 : remReg;
      srcDiv  = iStart ? iDivisor : divReg;
      srcQuo  = iStart ? iDividend : quoReg;
      trial   = {srcRem, srcQuo[DIVIDEND_W-1]};
      diff    = trial - {1'b0, srcDiv};
      take    = (trial >= {1'b0, srcDiv});
      // The restored remainder is always below the divisor, so it fits
      nextRem = take ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         remReg    <= '0;
         divReg    <= '0;
         quoReg    <= '0;
         cnt       <= '0;
         busy      <= 1'b0;
         oComplete <= 1'b0;
      end else begin
         oComplete <= 1'b0;
         if (iStart || busy) begin
            remReg <= nextRem;
            divReg <= srcDiv;
            // Dividend bits shift out at the top while quotient bits enter
            quoReg <= {srcQuo[DIVIDEND_W-2:0], take};
            if (iStart) begin
               cnt       <= CNT_W'(1);
               busy      <= (ITER > 1);
               oComplete <= (ITER == 1);
            end else begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) begin
                  busy      <= 1'b0;
                  oComplete <= 1'b1;
               end
            end
         end
      end
   end

   assign oQuotient  = quoReg;
   assign oRemainder = remReg;

endmodule

// File: rtl/inverse_actuator.sv
// ---------------------------------------------------------------------------
// inverse_actuator
// Computes x = y/(1-|y|) for a signed Q(FRAC) input, result in signed
// Q(FRAC) on OUT_W bits. Magnitudes |y| >= 1.0 saturate to +/-(2^(OUT_W-1)-1).
//   iClk    : clock
//   iRst_n  : synchronous active-low reset
//   bus     : inverse_actuator_if.slave (iData, iEn, oData, oComplete,
//             oBusy, oSat)
//   oState  : one-hot FSM state (IDLE, PREP, DIV, FINISH) for observation
// Latency from the accepting edge to the edge raising oComplete is
// 2*FRAC+2 cycles, or 2 cycles when saturating.
// Build macro INV_ACT_ROUND_EN: when defined, the quotient magnitude is
// rounded to nearest (ties up) instead of truncated; latency is unchanged.
// ---------------------------------------------------------------------------
module inverse_actuator
   import inv_act_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC   = DEF_FRAC,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic               iClk,
   input  logic               iRst_n,
   inverse_actuator_if.slave  bus,
   output state_t             oState
);

   localparam int QW = 2 * FRAC;

   // 1.0 in Q(FRAC), sized like the magnitude
   localparam logic [DATA_W:0] ONE_M =
      {{(DATA_W - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

   localparam logic signed [OUT_W-1:0] SAT_P = OUT_W'(SAT_POS(OUT_W));
   localparam logic signed [OUT_W-1:0] SAT_N = OUT_W'(SAT_NEG(OUT_W));

   state_t              state;
   logic [DATA_W-1:0]   yReg;
   logic                signReg;
   logic                satReg;

   logic                ySign;
   logic [DATA_W:0]     yExt;
   logic [DATA_W:0]     mag;
   logic                satNow;
   logic [QW-1:0]       dividend;
   logic [FRAC:0]       divisor;
   logic                divStart;

   logic [QW-1:0]       divQuo;
   logic [FRAC:0]       divRem;
   logic                divComplete;

   logic [QW:0]             magOut;
   logic signed [OUT_W-1:0] magExt;
   logic signed [OUT_W-1:0] result;

   // Sign/magnitude split of the captured value. The extra magnitude bit
   // keeps |-2^(DATA_W-1)| representable so it saturates like any |y|>=1.
   assign ySign    = yReg[DATA_W-1];
   assign yExt     = {ySign, yReg};
   assign mag      = ySign ? (~yExt + 1'b1) : yExt;
   assign satNow   = (mag >= ONE_M);
   // Below saturation the magnitude fits in FRAC bits
   assign dividend = {mag[FRAC-1:0], {FRAC{1'b0}}};
   assign divisor  = ONE_M[FRAC:0] - mag[FRAC:0];
   assign divStart = (state == ST_PREP) && !satNow;

   serial_divider #(
      .DIVIDEND_W (QW),
      .DIVISOR_W  (FRAC + 1),
      .ITER       (QW)
   ) u_div (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iStart     (divStart),
      .iDividend  (dividend),
      .iDivisor   (divisor),
      .oQuotient  (divQuo),
      .oRemainder (divRem),
      .oComplete  (divComplete)
   );

`ifdef INV_ACT_ROUND_EN
   logic [FRAC:0] divisorReg;
   logic          roundUp;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         divisorReg <= '0;
      end else if (state == ST_PREP) begin
         divisorReg <= divisor;
      end
   end

   // Round half up: the discarded fraction is remainder/divisor
   assign roundUp = ({divRem, 1'b0} >= {1'b0, divisorReg});
   assign magOut  = {1'b0, divQuo} + {{QW{1'b0}}, roundUp};
`else
   logic unusedRem;

   assign unusedRem = ^divRem;
   assign magOut    = {1'b0, divQuo};
`endif

   // OUT_W >= 2*FRAC+1, so the magnitude zero-extends without loss
   assign magExt = OUT_W'(magOut);
   assign result = signReg ? -magExt : magExt;

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state         <= ST_IDLE;
         yReg          <= '0;
         signReg       <= 1'b0;
         satReg        <= 1'b0;
         bus.oData     <= '0;
         bus.oSat      <= 1'b0;
         bus.oComplete <= 1'b0;
      end else begin
         bus.oComplete <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.iEn) begin
                  yReg  <= bus.iData;
                  state <= ST_PREP;
               end
            end
            ST_PREP: begin
               signReg <= ySign;
               satReg  <= satNow;
               state   <= satNow ? ST_FINISH : ST_DIV;
            end
            ST_DIV: begin
               if (divComplete) begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               if (satReg) begin
                  bus.oData <= signReg ? SAT_N : SAT_P;
               end else begin
                  bus.oData <= result;
               end
               bus.oSat      <= satReg;
               bus.oComplete <= 1'b1;
               state         <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.oBusy = (state != ST_IDLE);
   assign oState    = state;

endmodule

// File: tb/tb_inverse_actuator.sv
// ---------------------------------------------------------------------------
// tb_inverse_actuator
// Directed bench for inverse_actuator with DATA_W=16, FRAC=14, OUT_W=32.
// Expected results are hand-computed from x = y/(1-|y|) in Q14.
// Build macro INV_ACT_ROUND_EN selects the rounded expectation for y=9830.
// ---------------------------------------------------------------------------
module tb_inverse_actuator;
   import inv_act_pkg::*;

   logic   clk = 1'b0;
   logic   rstN;
   state_t dbgState;

   int nAsserts = 0;
   int nFail    = 0;
   int lat;
   int extra;

   inverse_actuator_if #(.DATA_W(16), .OUT_W(32)) bus ();

   inverse_actuator #(
      .DATA_W (16),
      .FRAC   (14),
      .OUT_W  (32)
   ) dut (
      .iClk   (clk),
      .iRst_n (rstN),
      .bus    (bus),
      .oState (dbgState)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      nAsserts++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present a request for one sampling edge; returns at the negedge after it
   task automatic start(input logic signed [15:0] y);
      @(negedge clk);
      bus.iData = y;
      bus.iEn   = 1'b1;
      @(negedge clk);
      bus.iEn   = 1'b0;
   endtask

   // Edges counted from the sampling edge until oComplete is seen
   task automatic wait_complete(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.oComplete && n < limit);
   endtask

   task automatic run(input string tag, input logic signed [15:0] y,
                      input logic signed [63:0] expData, input logic expSat,
                      input int expLat);
      int n;
      start(y);
      wait_complete(100, n);
      check({tag, "_latency"}, n, expLat);
      check({tag, "_data"}, bus.oData, expData);
      check({tag, "_sat"}, bus.oSat, expSat);
      @(negedge clk);
      check({tag, "_pulse_end"}, bus.oComplete, 0);
      check({tag, "_hold"}, bus.oData, expData);
      check({tag, "_idle"}, bus.oBusy, 0);
   endtask

   initial begin
      // Reset
      rstN      = 1'b0;
      bus.iEn   = 1'b0;
      bus.iData = '0;
      repeat (3) @(negedge clk);
      check("rst_data", bus.oData, 0);
      check("rst_complete", bus.oComplete, 0);
      check("rst_busy", bus.oBusy, 0);
      check("rst_sat", bus.oSat, 0);
      check("rst_state", dbgState, ST_IDLE);
      rstN = 1'b1;

      // Busy rises after the sampling edge
      start(16'sd8192);
      check("busy_high", bus.oBusy, 1);
      wait_complete(100, lat);
      check("half_latency", lat, 30);
      check("half_data", bus.oData, 16384);
      check("half_sat", bus.oSat, 0);

      run("neg_half", -16'sd8192, -16384, 1'b0, 30);
`ifdef INV_ACT_ROUND_EN
      run("y9830", 16'sd9830, 24574, 1'b0, 30);
`else
      run("y9830", 16'sd9830, 24573, 1'b0, 30);
`endif
      run("max_lin", 16'sd16383, 268419072, 1'b0, 30);
      run("sat_pos", 16'sd16384, 64'sh7FFFFFFF, 1'b1, 2);
      run("sat_neg", -16'sd32768, 32'sh80000001, 1'b1, 2);
      // 4096/12288 in Q14: remainder below half, same in both builds
      run("quarter", 16'sd4096, 5461, 1'b0, 30);

      // Back-to-back: new request in the oComplete cycle, noise while busy
      start(16'sd8192);
      wait_complete(100, lat);
      check("b2b_first", bus.oData, 16384);
      bus.iData = 16'sd12288;
      bus.iEn   = 1'b1;
      @(negedge clk);
      bus.iEn   = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 5 || lat == 20) begin
            bus.iData = -16'sd8192;
            bus.iEn   = 1'b1;
         end else begin
            bus.iEn   = 1'b0;
         end
      end while (!bus.oComplete && lat < 100);
      bus.iEn = 1'b0;
      check("b2b_latency", lat, 30);
      check("b2b_data", bus.oData, 49152);
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.oComplete) extra++;
      end
      check("busy_ignored", extra, 0);
      check("b2b_hold", bus.oData, 49152);

      // Reset in the middle of the division
      start(16'sd8192);
      repeat (11) @(negedge clk);
      check("mid_state", dbgState, ST_DIV);
      rstN = 1'b0;
      @(negedge clk);
      check("abort_data", bus.oData, 0);
      check("abort_busy", bus.oBusy, 0);
      check("abort_complete", bus.oComplete, 0);
      check("abort_state", dbgState, ST_IDLE);
      rstN  = 1'b1;
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.oComplete) extra++;
      end
      check("abort_no_pulse", extra, 0);

      // Zero goes through the full division
      run("zero", 16'sd0, 0, 1'b0, 30);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nAsserts, nFail);
      $finish;
   end

endmodule

// File: doc/inverse_actuator.md
INVERSE_ACTUATOR -- requirements
Module: inverse_actuator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the signed input width.
REQ-002 SHALL have parameter FRAC, default 14, giving the fractional bits of both input and output; the constraint is FRAC <= DATA_W-2.
REQ-003 SHALL have parameter OUT_W, default 32, giving the signed output width; the constraint is OUT_W >= 2*FRAC+1.
REQ-004 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-005 iRst_n  in  1  reset; synchronous, active-low.
REQ-006 iData  in  DATA_W  signed Q(FRAC) activation value y.
REQ-007 iEn  in  1  start request; sampled only in IDLE.
REQ-008 oData  out  OUT_W  signed Q(FRAC) result x = y/(1-|y|).
REQ-009 oComplete  out  1  one-cycle pulse: oData newly valid.
REQ-010 oBusy  out  1  high in any state other than IDLE.
REQ-011 oSat  out  1  result was saturated; valid with oData.

Function
REQ-012 SHALL implement the FSM states IDLE, PREP, DIV and FINISH.
REQ-013 IDLE with iEn=1 SHALL capture iData and go to PREP; iEn in any other state SHALL be ignored.
REQ-014 PREP SHALL compute the following, then go to DIV, or to FINISH if saturating:
- sign = y[MSB];
- m = |y| in DATA_W+1 bits;
- dividend = m << FRAC;
- divisor = 2^FRAC - m.
REQ-015 Saturation SHALL occur when m >= 2^FRAC, which includes y = -2^(DATA_W-1).
REQ-016 Saturated output SHALL be +(2^(OUT_W-1)-1) for positive y and -(2^(OUT_W-1)-1) for negative y, with oSat=1.
REQ-017 DIV SHALL run restoring long division, one quotient bit per cycle, for exactly 2*FRAC cycles, MSB first.
REQ-018 FINISH SHALL perform the following in one cycle, then return to IDLE:
- negate the magnitude if sign=1;
- zero-extend or negate into OUT_W bits;
- register oData and oSat;
- pulse oComplete.
REQ-019 Latency from the iEn-sampling edge to the edge that raises oComplete SHALL be 2*FRAC+2 cycles normally and 2 cycles on saturation.
REQ-020 y=0 SHALL yield oData=0 and oSat=0 through the full division path (no shortcut).
REQ-021 oData and oSat SHALL hold their values until the next FINISH.
REQ-022 iEn=1 in the cycle where oComplete=1 SHALL be accepted (FSM is in IDLE), permitting back-to-back operations.
REQ-023 Without rounding, the quotient magnitude SHALL be truncated toward zero.

Reset
REQ-024 iRst_n=0 at a rising edge SHALL force the following:
- state=IDLE;
- oData=0;
- oComplete=0;
- oBusy=0;
- oSat=0;
- all datapath registers cleared.
REQ-025 Reset during PREP, DIV or FINISH SHALL abort the operation, with no oComplete pulse issued for it.

Configuration
REQ-026 Macro INV_ACT_ROUND_EN, when defined, SHALL round the magnitude to nearest: after the last DIV step, if 2*remainder >= divisor, the magnitude is incremented; latency is unchanged.
REQ-027 When INV_ACT_ROUND_EN is undefined, the magnitude SHALL be truncated and no rounding logic shall be synthesized.

Structure
REQ-028 A shared package inv_act_pkg SHALL hold the following; modules import it:
- the FSM state typedef (one-hot, 4 bits);
- default DATA_W, FRAC and OUT_W constants;
- the SAT_POS and SAT_NEG constant functions of OUT_W.
REQ-029 The serial division SHALL be a sub-module serial_divider with the following ports and behaviour:
- iClk, iRst_n, iStart, iDividend, iDivisor, oQuotient, oRemainder, oComplete;
- iterations parameterized;
- remainder exposed for rounding.
REQ-030 The top level SHALL contain only the FSM, sign/magnitude handling, saturation and output registers.

Verification (DATA_W=16, FRAC=14, OUT_W=32)
REQ-031 y=8192 (0.5): oData=16384, oSat=0, and oComplete exactly 30 cycles after the iEn edge. y=-8192: oData=-16384.
REQ-032 y=9830: oData=24573 when INV_ACT_ROUND_EN is undefined and 24574 when it is defined. y=16383: oData=268419072.
REQ-033 Saturation:
- y=16384: oData=0x7FFFFFFF, oSat=1, latency 2 cycles.
- y=-32768: oData=0x80000001, oSat=1.
REQ-034 Second iEn (y=12288) asserted in the same cycle as the first oComplete: accepted, with oData=49152 exactly 30 cycles later. iEn pulses while oBusy=1 are ignored.
REQ-035 Reset pulsed at DIV cycle 10: no oComplete, oData=0, oBusy=0 on the next cycle. A following iEn (y=0) completes normally with oData=0.
